// File: rtl/if_fetch_unit.sv
// if_fetch_unit: stage-1 instruction fetch between the PC register and IF/ID.
// Issues one I-cache request at a time for pc_in and captures the returned word
// into the IF/ID register. A one-entry skid buffer absorbs a response that
// arrives while decode is stalled. Redirects flush the slot and kill any
// in-flight fetch.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   pc_in               current PC (PC register output)
//   pc_redirect         execute is loading a branch/jump target into the PC
//   id_stall            decode cannot accept a new instruction this cycle
//   icache_req_*        request handshake (valid/ready), icache_addr = pc_in[31:2]
//   icache_resp_*       response word, sampled only while waiting for it
//   inst_out/inst_pc    IF/ID instruction and its PC
//   inst_valid          inst_out holds a real instruction
//   fetch_stall         to the PC register's stall input
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_redirect,
  input  logic        id_stall,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [29:0] icache_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_data,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_stall
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_dat_q, skid_dat_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_vld_q, inst_vld_d;

  logic        out_blocked;
  logic        fire;
  logic        load;
  logic [31:0] load_dat;
  logic [31:0] load_pc;

  assign out_blocked = inst_vld_q & id_stall;

  // No request in a redirect cycle: pc_in is still the wrong-path PC.
  // Reset gates the request so nothing escapes while the cache is in reset.
  assign icache_req_valid = (state_q == ST_REQ) & ~out_blocked & ~pc_redirect & ~reset;
  assign fire             = icache_req_valid & icache_req_ready;
  assign icache_addr      = pc_in[31:2];

  // The PC only moves on an issuing edge or a redirect edge, which keeps
  // icache_addr stable for as long as a request is pending.
  assign fetch_stall = reset | (~fire & ~pc_redirect);

  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_vld_q;

  // Fetch sequencing and skid buffer.
  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    skid_pc_d  = skid_pc_q;
    load       = 1'b0;
    load_dat   = icache_resp_data;
    load_pc    = req_pc_q;

    case (state_q)
      ST_REQ: begin
        if (fire) begin
          state_d  = ST_WAIT;
          req_pc_d = pc_in;
        end
      end

      ST_WAIT: begin
        if (icache_resp_valid) begin
          if (kill_q || pc_redirect) begin
            // Wrong-path word: drop it.
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else if (!out_blocked) begin
            load    = 1'b1;
            state_d = ST_REQ;
          end else begin
            skid_vld_d = 1'b1;
            skid_dat_d = icache_resp_data;
            skid_pc_d  = req_pc_q;
            state_d    = ST_HOLD;
          end
        end else if (pc_redirect) begin
          // Response still in flight; remember to drop it when it lands.
          kill_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (pc_redirect) begin
          state_d = ST_REQ;
        end else if (!id_stall) begin
          load       = 1'b1;
          load_dat   = skid_dat_q;
          load_pc    = skid_pc_q;
          skid_vld_d = 1'b0;
          state_d    = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    if (pc_redirect) begin
      skid_vld_d = 1'b0;
    end
  end

  // IF/ID register: flush beats load, load beats consume.
  always_comb begin
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_vld_d = inst_vld_q;

    if (pc_redirect) begin
      inst_vld_d = 1'b0;
      inst_d     = NOP_INST;
    end else if (load) begin
      inst_d     = load_dat;
      inst_pc_d  = load_pc;
      inst_vld_d = 1'b1;
    end else if (inst_vld_q && !id_stall) begin
      // Decode took the instruction; inst_pc is intentionally left as is.
      inst_vld_d = 1'b0;
      inst_d     = NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_REQ;
      req_pc_q   <= RESET_PC;
      kill_q     <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= NOP_INST;
      skid_pc_q  <= RESET_PC;
      inst_q     <= NOP_INST;
      inst_pc_q  <= RESET_PC;
      inst_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_pc_q  <= skid_pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_vld_q <= inst_vld_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: PC register and I-cache modelled in the bench,
// transaction-level reference model, directed scenarios then random traffic.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_2000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_redirect;
  logic        id_stall;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [29:0] icache_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_stall;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_in             (pc_in),
    .pc_redirect       (pc_redirect),
    .id_stall          (id_stall),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_addr       (icache_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .inst_out          (inst_out),
    .inst_pc           (inst_pc),
    .inst_valid        (inst_valid),
    .fetch_stall       (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus chosen by the scenario code.
  logic        stall_s, ready_s, redir_s;
  logic [31:0] tgt_s;
  int          c_delay;

  // Bench-side PC register and cache.
  logic [31:0] pc_q;
  logic        c_busy;
  int          c_cnt;
  logic [31:0] c_pc;
  logic        r_vld;
  logic [31:0] r_dat;

  // Reference model: IF/ID slot, one pending fetch, one parked word.
  logic        m_valid;
  logic [31:0] m_out, m_pc;
  logic        m_pend, m_kill;
  logic [31:0] m_req_pc;
  logic        m_skid;
  logic [31:0] m_skid_dat, m_skid_pc;

  logic [63:0] cap[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_out = NOP_INST; m_pc = RESET_PC;
    m_pend = 1'b0; m_kill = 1'b0; m_skid = 1'b0;
    m_req_pc = RESET_PC; m_skid_dat = 32'h0; m_skid_pc = 32'h0;
    c_busy = 1'b0; c_cnt = 0; c_pc = 32'h0;
  endtask

  // One clock cycle: drive at negedge, compare 1 ns later, then advance the
  // model to what must hold after the coming rising edge. Returns before
  // that edge so scenario code can add literal checks for this cycle.
  task automatic step();
    logic blk, e_rv, e_fire, e_fs, loaded;
    @(negedge clk);
    id_stall         = stall_s;
    icache_req_ready = ready_s;
    pc_redirect      = redir_s;
    pc_in            = pc_q;
    r_vld = 1'b0;
    r_dat = $urandom;
    if (c_busy) begin
      c_cnt--;
      if (c_cnt == 0) begin
        r_vld = 1'b1;
        r_dat = mem_word(c_pc);
      end
    end
    icache_resp_valid = r_vld;
    icache_resp_data  = r_dat;
    #1;

    blk    = m_valid & stall_s;
    e_rv   = !m_pend && !m_skid && !blk && !redir_s;
    e_fire = e_rv && ready_s;
    e_fs   = !e_fire && !redir_s;

    chk("req_valid",   icache_req_valid, e_rv);
    chk("fetch_stall", fetch_stall,      e_fs);
    chk("inst_valid",  inst_valid,       m_valid);
    chk("inst_out",    inst_out,         m_out);
    chk("inst_pc",     inst_pc,          m_pc);
    if (e_rv) chk("icache_addr", icache_addr, pc_q[31:2]);

    if (redir_s) begin
      if (m_pend) begin
        if (r_vld) begin m_pend = 1'b0; m_kill = 1'b0; end
        else m_kill = 1'b1;
      end
      m_skid  = 1'b0;
      m_valid = 1'b0;
      m_out   = NOP_INST;
    end else begin
      loaded = 1'b0;
      if (m_skid) begin
        if (!stall_s) begin
          m_out = m_skid_dat; m_pc = m_skid_pc; m_valid = 1'b1;
          m_skid = 1'b0; loaded = 1'b1;
        end
      end else if (m_pend && r_vld) begin
        m_pend = 1'b0;
        if (m_kill) m_kill = 1'b0;
        else if (!blk) begin
          m_out = r_dat; m_pc = m_req_pc; m_valid = 1'b1; loaded = 1'b1;
        end else begin
          m_skid = 1'b1; m_skid_dat = r_dat; m_skid_pc = m_req_pc;
        end
      end
      if (!loaded && m_valid && !stall_s) begin
        m_valid = 1'b0;
        m_out   = NOP_INST;
      end
      if (e_fire) begin
        m_pend   = 1'b1;
        m_req_pc = pc_q;
      end
    end

    if (r_vld) c_busy = 1'b0;
    if (e_fire) begin
      c_busy = 1'b1; c_cnt = c_delay; c_pc = pc_q;
    end
    if (!e_fs) pc_q = redir_s ? tgt_s : pc_q + 32'd4;
  endtask

  initial begin
    reset = 1'b1;
    pc_q = RESET_PC; pc_in = RESET_PC;
    pc_redirect = 1'b0; id_stall = 1'b0; icache_req_ready = 1'b0;
    icache_resp_valid = 1'b0; icache_resp_data = 32'h0;
    stall_s = 1'b0; ready_s = 1'b0; redir_s = 1'b0; tgt_s = 32'h0; c_delay = 1;
    model_reset();

    // Values while reset is held.
    repeat (3) @(negedge clk);
    #1;
    chk("rst inst_out",   inst_out,         32'h0000_0013);
    chk("rst inst_pc",    inst_pc,          32'h0000_2000);
    chk("rst inst_valid", inst_valid,       1'b0);
    chk("rst req_valid",  icache_req_valid, 1'b0);
    chk("rst fetch_stall", fetch_stall,     1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Free run: always ready, one-cycle cache.
    stall_s = 1'b0; ready_s = 1'b1; redir_s = 1'b0; c_delay = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (inst_valid) cap.push_back({inst_pc, inst_out});
    end
    chk("free count", cap.size(), 3);
    if (cap.size() >= 3) begin
      chk("free pc0",   cap[0][63:32], 32'h0000_2000);
      chk("free inst0", cap[0][31:0],  32'hFFFF_DFFF);
      chk("free pc1",   cap[1][63:32], 32'h0000_2004);
      chk("free inst1", cap[1][31:0],  32'hFFFF_DFFB);
      chk("free pc2",   cap[2][63:32], 32'h0000_2008);
      chk("free inst2", cap[2][31:0],  32'hFFFF_DFF7);
    end

    // Decode back-pressure while the 0x200C word sits in IF/ID.
    stall_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp req_valid",  icache_req_valid, 1'b0);
      chk("bp inst_valid", inst_valid,       1'b1);
      chk("bp inst_out",   inst_out,         32'hFFFF_DFF3);
    end

    // Redirect to 0x3000 while the fetch of 0x2010 is in flight.
    stall_s = 1'b0; c_delay = 2;
    step();                                   // fire 0x2010
    redir_s = 1'b1; tgt_s = 32'h0000_3000;
    step();                                   // WAIT, no response yet
    redir_s = 1'b0; c_delay = 1;
    step();                                   // stale response arrives
    step();
    chk("redir req_valid", icache_req_valid, 1'b1);
    chk("redir addr",      icache_addr,      30'h0C00);
    step();
    step();
    chk("redir inst_valid", inst_valid, 1'b1);
    chk("redir inst_pc",    inst_pc,    32'h0000_3000);
    chk("redir inst_out",   inst_out,   32'hFFFF_CFFF);

    // Redirect coinciding with a response and a decode stall.
    redir_s = 1'b1; stall_s = 1'b1; tgt_s = 32'h0000_3100;
    step();
    redir_s = 1'b0; stall_s = 1'b0; ready_s = 1'b0;
    step();
    chk("flush inst_valid", inst_valid, 1'b0);
    chk("flush inst_out",   inst_out,   32'h0000_0013);

    // Cache not ready for four cycles.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("nrdy req_valid",   icache_req_valid, 1'b1);
      chk("nrdy addr",        icache_addr,      30'h0C40);
      chk("nrdy fetch_stall", fetch_stall,      1'b1);
      chk("nrdy pc_in",       pc_in,            32'h0000_3100);
    end
    ready_s = 1'b1; c_delay = 3;
    step();                                   // fire 0x3100
    step();                                   // WAIT

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst inst_valid",  inst_valid,       1'b0);
    chk("arst inst_out",    inst_out,         32'h0000_0013);
    chk("arst inst_pc",     inst_pc,          32'h0000_2000);
    chk("arst req_valid",   icache_req_valid, 1'b0);
    chk("arst fetch_stall", fetch_stall,      1'b1);
    pc_q = 32'h0000_4000; pc_in = pc_q;
    icache_req_ready = 1'b0; icache_resp_valid = 1'b0; pc_redirect = 1'b0; id_stall = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ready_s = 1'b1; c_delay = 1;
    step();
    chk("restart req_valid", icache_req_valid, 1'b1);
    chk("restart addr",      icache_addr,      30'h1000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      stall_s = ($urandom_range(0, 3) == 0);
      ready_s = ($urandom_range(0, 2) != 0);
      redir_s = ($urandom_range(0, 11) == 0);
      tgt_s   = 32'h0000_5000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      c_delay = $urandom_range(1, 3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
